pt_frame_seq: RTL and testbench
===============================

PT_FRAME_SEQ -- requirements
Module: pt_frame_seq

Interface
REQ-001 Parameters: N, default 12, frame word width in bits (N>=2).
REQ-002 Parameters: BIT_DIV, default 4, clk cycles per bit slot (>=1).
REQ-003 Parameters: SYNC_LEN, default 8, sync-gap length in bit slots (>=1).
REQ-004 Parameters: REPEAT, default 4, frames sent per request (>=1).
REQ-005 Ports: clk input 1, the single clock; rst input 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 Ports: start input 1 requests transmission; word input N is the frame payload, sampled when start is accepted; abort input 1 cancels transmission.
REQ-007 Ports: sr_op output 2 and sr_d output N drive shift-register OP and d; sr_shift_in output 1 drives shift_in; sr_strobe output 1 drives the shift-register enable.
REQ-008 Ports: sr_bit_in input 1 carries the shift-register shift_out_left (MSB).
REQ-009 Ports: tx_bit output 1 is the current serial bit; tx_valid output 1 marks a bit slot; sync output 1 marks the sync gap; busy output 1; done output 1 is a one-cycle completion pulse.

Function
REQ-010 The FSM states are IDLE, LOAD, SHIFT, SYNC and DONE; all outputs are registered.
- IDLE: start=1 latches word into word_q and sets the frame counter to 0 -> LOAD.
- LOAD: one cycle; sr_op=11, sr_d=word_q, sr_strobe=1 -> SHIFT.
- SHIFT: bit counter 0..N-1, slot counter 0..BIT_DIV-1; tx_valid=1 and tx_bit=sr_bit_in throughout.
- On the last cycle of each slot, sr_op=01, sr_shift_in=0, sr_strobe=1 (shift left).
- After slot N-1 -> SYNC.
- SYNC: SYNC_LEN*BIT_DIV cycles with sync=1, tx_valid=0, tx_bit=0.
- At the end of SYNC, the frame counter increments; if frame counter+1<REPEAT -> LOAD, else -> DONE.
- DONE: one cycle; done=1 -> IDLE.
REQ-011 sr_strobe is high for exactly one clk cycle per load or shift, and low in all other cycles.
REQ-012 When sr_strobe is low, sr_op SHALL be 00 (hold).
REQ-013 Timing, with start accepted at edge t0:
- LOAD occupies cycle t0+1.
- The first SHIFT cycle is t0+2, and tx_bit equals word[N-1] in that cycle.
- Each frame is 1+(N+SYNC_LEN)*BIT_DIV cycles.
- done is high exactly REPEAT*(1+(N+SYNC_LEN)*BIT_DIV) cycles after t0+1.
REQ-014 busy is 1 in LOAD, SHIFT, SYNC and DONE, and 0 in IDLE.
REQ-015 start asserted while busy=1 is ignored and is not queued; word changes while busy=1 have no effect.
REQ-016 Bits are transmitted MSB first; each frame reloads from word_q, so every repeat carries the identical bit sequence.
REQ-017 Counters are sized with $clog2 of their ranges. No counter wraps past its terminal value; each terminal count causes the state transition.
REQ-018 start and abort asserted together in IDLE: start takes priority when FRAME_SEQ_ABORT_EN is undefined. When the macro is defined, abort wins and the FSM stays in IDLE.

Reset
REQ-019 With rst=1 at a clk edge, the FSM enters IDLE; all counters and word_q clear to 0.
REQ-020 Reset values: sr_op=00, sr_d=0, sr_shift_in=0, sr_strobe=0, tx_bit=0, tx_valid=0, sync=0, busy=0, done=0.
REQ-021 rst asserted mid-frame takes effect at that edge; no done pulse is issued and no further strobes occur.

Configuration
REQ-022 Macro FRAME_SEQ_ABORT_EN controls the abort function.
- Defined: abort=1 in any non-IDLE state forces IDLE at the next edge, with outputs at reset values and no done pulse.
- Undefined: the abort port exists but is ignored.

Verification
REQ-023 Parameters N=4, BIT_DIV=2, SYNC_LEN=3, REPEAT=2 with a behavioural shift-register model attached; start pulse with word=4'b1011 -> tx_bit slots 1,0,1,1 and a 6-cycle sync gap, sent twice. done pulses 30 cycles after the first LOAD cycle; sr_strobe count is 10 (2 loads, 8 shifts).
REQ-024 Same setup; start pulse with word=1011, then start with word=0000 during SHIFT -> the second request is ignored, and both frames carry 1011.
REQ-025 Same setup; rst=1 during SYNC of frame 0 -> all outputs reach reset values at that edge; done never pulses; start with word=0110 afterwards transmits 0,1,1,0.
REQ-026 Same setup with FRAME_SEQ_ABORT_EN defined; abort during SHIFT bit 2 -> IDLE at the next edge, busy=0, no done pulse. The same stimulus without the macro -> the full 30-cycle sequence completes.
REQ-027 Defaults N=12, BIT_DIV=4, SYNC_LEN=8, REPEAT=4; word=12'hA5C -> tx_bit bit stream matches 101001011100 per frame; done pulses 324 cycles after the first LOAD cycle.

Source files
------------

// File: rtl/pt_frame_seq_if.sv
// Bundle of the request, shift-register and serial-output signals for pt_frame_seq.
interface pt_frame_seq_if #(
  parameter int N = 12
);
  logic         start;
  logic [N-1:0] word;
  logic         abort;
  logic [1:0]   sr_op;
  logic [N-1:0] sr_d;
  logic         sr_shift_in;
  logic         sr_strobe;
  logic         sr_bit_in;
  logic         tx_bit;
  logic         tx_valid;
  logic         sync;
  logic         busy;
  logic         done;

  modport master (
    output start, word, abort, sr_bit_in,
    input  sr_op, sr_d, sr_shift_in, sr_strobe, tx_bit, tx_valid, sync, busy, done
  );

  modport slave (
    input  start, word, abort, sr_bit_in,
    output sr_op, sr_d, sr_shift_in, sr_strobe, tx_bit, tx_valid, sync, busy, done
  );
endinterface

// File: rtl/pt_frame_seq.sv
// Frame sequencer: drives an external shift register to send a word MSB first REPEAT times,
// each frame followed by a sync gap. Define FRAME_SEQ_ABORT_EN to enable the abort input.
module pt_frame_seq #(
  parameter int N        = 12,
  parameter int BIT_DIV  = 4,
  parameter int SYNC_LEN = 8,
  parameter int REPEAT   = 4
) (
  input  logic           clk,
  input  logic           rst,
  pt_frame_seq_if.slave  bus
);

  localparam int GAP = SYNC_LEN * BIT_DIV;
  localparam int BW  = (N > 1)       ? $clog2(N)       : 1;
  localparam int SW  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GW  = (GAP > 1)     ? $clog2(GAP)     : 1;
  localparam int FW  = (REPEAT > 1)  ? $clog2(REPEAT)  : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(BIT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(REPEAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SYNC, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] frame_q, frame_d;

  logic [1:0]    sr_op_q, sr_op_d;
  logic [N-1:0]  sr_d_q, sr_d_d;
  logic          sr_strobe_q, sr_strobe_d;
  logic          tx_valid_q, tx_valid_d;
  logic          sync_q, sync_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_in;

`ifdef FRAME_SEQ_ABORT_EN
  assign abort_in = bus.abort;
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_in     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !abort_in) begin
          word_d  = bus.word;
          frame_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bit_d   = '0;
        slot_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (bit_q == BIT_LAST) begin
            gap_d   = '0;
            state_d = SYNC;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      SYNC: begin
        if (gap_q == GAP_LAST) begin
          if (frame_q != FRAME_LAST) begin
            frame_d = frame_q + FW'(1);
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_in && (state_q != IDLE)) begin
      state_d = IDLE;
      bit_d   = '0;
      slot_d  = '0;
      gap_d   = '0;
      frame_d = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    sync_d      = (state_d == SYNC);
    tx_valid_d  = (state_d == SHIFT);
    sr_strobe_d = 1'b0;
    sr_op_d     = 2'b00;
    sr_d_d      = '0;
    if (state_d == LOAD) begin
      sr_strobe_d = 1'b1;
      sr_op_d     = 2'b11;
      sr_d_d      = word_d;
    end else if ((state_d == SHIFT) && (slot_d == SLOT_LAST)) begin
      sr_strobe_d = 1'b1;
      sr_op_d     = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bit_q       <= '0;
      slot_q      <= '0;
      gap_q       <= '0;
      frame_q     <= '0;
      sr_op_q     <= 2'b00;
      sr_d_q      <= '0;
      sr_strobe_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      gap_q       <= gap_d;
      frame_q     <= frame_d;
      sr_op_q     <= sr_op_d;
      sr_d_q      <= sr_d_d;
      sr_strobe_q <= sr_strobe_d;
      tx_valid_q  <= tx_valid_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The serial bit already comes from the shift-register flops; it is only gated by the slot flag.
  assign bus.tx_bit      = tx_valid_q & bus.sr_bit_in;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.sync        = sync_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sr_op       = sr_op_q;
  assign bus.sr_d        = sr_d_q;
  assign bus.sr_strobe   = sr_strobe_q;
  assign bus.sr_shift_in = 1'b0;

endmodule

// File: tb/tb_pt_frame_seq.sv
// Directed bench for pt_frame_seq: a small N=4 instance and a default-parameter instance,
// each with a behavioural shift register attached.
module tb_pt_frame_seq;

  localparam int AN = 4, ABD = 2, ASL = 3, ARP = 2;
  localparam int BN = 12, BBD = 4, BSL = 8, BRP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pt_frame_seq_if #(.N(AN)) a_if ();
  pt_frame_seq_if #(.N(BN)) b_if ();

  pt_frame_seq #(.N(AN), .BIT_DIV(ABD), .SYNC_LEN(ASL), .REPEAT(ARP)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  pt_frame_seq #(.N(BN), .BIT_DIV(BBD), .SYNC_LEN(BSL), .REPEAT(BRP)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  logic [AN-1:0] sr_a = '0;
  logic [BN-1:0] sr_b = '0;

  always @(posedge clk) begin
    if (a_if.sr_strobe) begin
      if (a_if.sr_op == 2'b11)      sr_a <= a_if.sr_d;
      else if (a_if.sr_op == 2'b01) sr_a <= {sr_a[AN-2:0], a_if.sr_shift_in};
    end
    if (b_if.sr_strobe) begin
      if (b_if.sr_op == 2'b11)      sr_b <= b_if.sr_d;
      else if (b_if.sr_op == 2'b01) sr_b <= {sr_b[BN-2:0], b_if.sr_shift_in};
    end
  end
  assign a_if.sr_bit_in = sr_a[AN-1];
  assign b_if.sr_bit_in = sr_b[BN-1];

  int compared   = 0;
  int mismatched = 0;

  int          done_n, done_at, strobes, bad_op, nv, nsync, bad_sync, late_busy;
  logic [63:0] stream;
  logic [7:0]  first_snap;
  logic [11:0] ev_snap;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Slot-by-slot stream the small instance should emit: each word bit held for ABD cycles.
  function automatic logic [63:0] expStream(input logic [AN-1:0] w, input int nbits);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < nbits; i++) s[i] = w[AN-1-((i/ABD)%AN)];
    return s;
  endfunction

  task automatic applyStimulus(input logic [AN-1:0] w, input logic with_abort);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.word  = w;
    a_if.abort = with_abort;
    @(negedge clk);
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
  endtask

  // Cycle 0 is the LOAD cycle; events are driven at cycle c and take effect at the next edge.
  task automatic monSmall(input int restart_c, input int rst_c, input int abort_c,
                          input int snap_c, input int ncyc);
    done_n = 0; done_at = -1; strobes = 0; bad_op = 0; nv = 0; nsync = 0;
    bad_sync = 0; late_busy = 0; stream = '0; first_snap = '0; ev_snap = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) first_snap = {a_if.busy, a_if.sr_strobe, a_if.sr_op, a_if.sr_d};
      if (c == snap_c)
        ev_snap = {a_if.busy, a_if.done, a_if.sync, a_if.tx_valid, a_if.tx_bit,
                   a_if.sr_strobe, a_if.sr_op, a_if.sr_d};
      if (a_if.done) begin
        done_n++;
        done_at = c;
      end else if (done_at >= 0 && a_if.busy) begin
        late_busy++;
      end
      if (a_if.sr_strobe) strobes++;
      else if (a_if.sr_op != 2'b00) bad_op++;
      if (a_if.tx_valid) begin
        if (nv < 64) stream[nv] = a_if.tx_bit;
        nv++;
      end
      if (a_if.sync) begin
        nsync++;
        if (a_if.tx_valid || a_if.tx_bit) bad_sync++;
      end
      a_if.start = (c == restart_c);
      if (c == restart_c) a_if.word = '0;
      rst        = (c == rst_c);
      a_if.abort = (c == abort_c);
      @(negedge clk);
    end
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    a_if.start = 1'b0; a_if.word = '0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.word = '0; b_if.abort = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 64'({a_if.busy, a_if.done, a_if.sync, a_if.tx_valid, a_if.tx_bit,
                a_if.sr_strobe, a_if.sr_op, a_if.sr_d, a_if.sr_shift_in}), 64'd0);
    checkOutput("reset_b", 64'({b_if.busy, b_if.done, b_if.sync, b_if.tx_valid, b_if.tx_bit,
                b_if.sr_strobe, b_if.sr_op, b_if.sr_d, b_if.sr_shift_in}), 64'd0);
    rst = 1'b0;

    $display("[TB] basic frame pair, word 1011");
    applyStimulus(4'b1011, 1'b0);
    monSmall(-1, -1, -1, -1, 40);
    checkOutput("basic_load",     64'(first_snap), 64'h00FB);
    checkOutput("basic_done_at",  64'(done_at),    64'd30);
    checkOutput("basic_done_n",   64'(done_n),     64'd1);
    checkOutput("basic_strobes",  64'(strobes),    64'd10);
    checkOutput("basic_hold_op",  64'(bad_op),     64'd0);
    checkOutput("basic_nvalid",   64'(nv),         64'd16);
    checkOutput("basic_stream",   stream,          expStream(4'b1011, 16));
    checkOutput("basic_nsync",    64'(nsync),      64'd12);
    checkOutput("basic_sync_out", 64'(bad_sync),   64'd0);
    checkOutput("basic_idle",     64'(late_busy),  64'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(4'b1011, 1'b0);
    monSmall(3, -1, -1, -1, 40);
    checkOutput("busy_done_at", 64'(done_at),   64'd30);
    checkOutput("busy_stream",  stream,         expStream(4'b1011, 16));
    checkOutput("busy_strobes", 64'(strobes),   64'd10);
    checkOutput("busy_noqueue", 64'(late_busy), 64'd0);

    $display("[TB] reset during sync gap, then word 0110");
    applyStimulus(4'b1011, 1'b0);
    monSmall(-1, 10, -1, 11, 40);
    checkOutput("rst_outputs", 64'(ev_snap), 64'd0);
    checkOutput("rst_done_n",  64'(done_n),  64'd0);
    checkOutput("rst_strobes", 64'(strobes), 64'd5);
    checkOutput("rst_nvalid",  64'(nv),      64'd8);
    checkOutput("rst_stream",  stream,       expStream(4'b1011, 8));
    checkOutput("rst_nsync",   64'(nsync),   64'd2);
    applyStimulus(4'b0110, 1'b0);
    monSmall(-1, -1, -1, -1, 40);
    checkOutput("after_rst_load",    64'(first_snap), 64'h00F6);
    checkOutput("after_rst_stream",  stream,          expStream(4'b0110, 16));
    checkOutput("after_rst_done_at", 64'(done_at),    64'd30);

    $display("[TB] abort during bit 2");
    applyStimulus(4'b1011, 1'b0);
    monSmall(-1, -1, 5, 6, 40);
`ifdef FRAME_SEQ_ABORT_EN
    checkOutput("abort_outputs", 64'(ev_snap), 64'd0);
    checkOutput("abort_done_n",  64'(done_n),  64'd0);
    checkOutput("abort_strobes", 64'(strobes), 64'd3);
    checkOutput("abort_stream",  stream,       expStream(4'b1011, 5));
`else
    checkOutput("abort_ign_snap",    64'(ev_snap), 64'h09D0);
    checkOutput("abort_ign_done_at", 64'(done_at), 64'd30);
    checkOutput("abort_ign_strobes", 64'(strobes), 64'd10);
    checkOutput("abort_ign_stream",  stream,       expStream(4'b1011, 16));
`endif

    $display("[TB] start and abort together in idle");
    applyStimulus(4'b1011, 1'b1);
    monSmall(-1, -1, -1, -1, 40);
`ifdef FRAME_SEQ_ABORT_EN
    checkOutput("both_idle_load",   64'(first_snap), 64'd0);
    checkOutput("both_idle_done_n", 64'(done_n),     64'd0);
`else
    checkOutput("both_idle_load",    64'(first_snap), 64'h00FB);
    checkOutput("both_idle_done_at", 64'(done_at),    64'd30);
`endif

    $display("[TB] default parameters, word A5C");
    begin
      int          b_done_at, b_done_n, b_strobes, b_nv, b_bad_slot;
      logic [47:0] b_bits;
      logic        b_prev;
      b_done_at = -1; b_done_n = 0; b_strobes = 0; b_nv = 0; b_bad_slot = 0;
      b_bits = '0; b_prev = 1'b0;
      @(negedge clk);
      b_if.start = 1'b1;
      b_if.word  = 12'hA5C;
      @(negedge clk);
      b_if.start = 1'b0;
      for (int c = 0; c < 340; c++) begin
        if (b_if.done) begin
          b_done_n++;
          b_done_at = c;
        end
        if (b_if.sr_strobe) b_strobes++;
        if (b_if.tx_valid) begin
          if (b_nv % BBD == 0) b_bits = {b_bits[46:0], b_if.tx_bit};
          else if (b_if.tx_bit != b_prev) b_bad_slot++;
          b_prev = b_if.tx_bit;
          b_nv++;
        end
        @(negedge clk);
      end
      checkOutput("dflt_bits",     64'(b_bits),     64'hA5CA5CA5CA5C);
      checkOutput("dflt_slot",     64'(b_bad_slot), 64'd0);
      checkOutput("dflt_nvalid",   64'(b_nv),       64'd192);
      checkOutput("dflt_strobes",  64'(b_strobes),  64'd52);
      checkOutput("dflt_done_at",  64'(b_done_at),  64'd324);
      checkOutput("dflt_done_n",   64'(b_done_n),   64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
